// File: rtl/div_unit.sv
// div_unit: iterative RV32M divide/remainder (DIV, DIVU, REM, REMU).
// Restoring division on operand magnitudes, one quotient bit per cycle,
// with the sign fixed up once on the way into DONE. The result leaves as
// a register-file write-back triple (rf_we, rf_waddr, rf_wdata).
//
// Handshake with the control unit:
//   start is sampled only while the unit is IDLE (busy=0); operands, op and
//   rd_addr are captured on that same edge and may change freely afterwards.
//   busy is high in every cycle the unit is not IDLE, so issue stalls on it.
//   done is a single-cycle pulse; rf_we/rf_waddr/rf_wdata are valid only in
//   that cycle and are zero in every other cycle. A start seen while busy is
//   dropped, not queued. rst wins over start.
module div_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] rs1_val,
  input  logic [DATA_WIDTH-1:0] rs2_val,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  busy,
  output logic                  done,
  output logic                  rf_we,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic [1:0]            dbg_state
);

  localparam int CNT_W = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_q, state_n;
  logic [CNT_W-1:0]      cnt_q, cnt_n;
  logic                  is_rem_q, is_rem_n;
  logic                  neg_q_q, neg_q_n;
  logic                  neg_r_q, neg_r_n;
  logic [ADDR_WIDTH-1:0] rd_q, rd_n;
  logic [DATA_WIDTH-1:0] dvs_q, dvs_n;
  logic [DATA_WIDTH-1:0] rem_q, rem_n;
  logic [DATA_WIDTH-1:0] quo_q, quo_n;
  logic                  done_q, done_n;
  logic                  we_q, we_n;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_n;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_n;

  // Operand preparation for the IDLE -> CALC capture.
  logic                  op_signed;
  logic [DATA_WIDTH-1:0] abs_rs1;
  logic [DATA_WIDTH-1:0] abs_rs2;

  // One restoring step: the partial remainder needs one extra bit because
  // the shifted remainder can reach just under twice the divisor.
  logic [DATA_WIDTH:0]   partial;
  logic [DATA_WIDTH:0]   trial;
  logic [DATA_WIDTH-1:0] step_rem;
  logic [DATA_WIDTH-1:0] step_quo;
  logic [DATA_WIDTH-1:0] final_mag;
  logic                  final_neg;

  // Datapath helpers shared by the next-state logic.
  always_comb begin
    op_signed = ~op[0];
    abs_rs1   = (op_signed && rs1_val[DATA_WIDTH-1]) ? -rs1_val : rs1_val;
    abs_rs2   = (op_signed && rs2_val[DATA_WIDTH-1]) ? -rs2_val : rs2_val;

    partial   = {rem_q, quo_q[DATA_WIDTH-1]};
    trial     = partial - {1'b0, dvs_q};
    if (!trial[DATA_WIDTH]) begin
      step_rem = trial[DATA_WIDTH-1:0];
      step_quo = {quo_q[DATA_WIDTH-2:0], 1'b1};
    end else begin
      step_rem = partial[DATA_WIDTH-1:0];
      step_quo = {quo_q[DATA_WIDTH-2:0], 1'b0};
    end

    final_mag = is_rem_q ? step_rem : step_quo;
    final_neg = is_rem_q ? neg_r_q : neg_q_q;
  end

  // Next-state, datapath and registered-output logic for the divide FSM.
  always_comb begin
    state_n  = state_q;
    cnt_n    = cnt_q;
    is_rem_n = is_rem_q;
    neg_q_n  = neg_q_q;
    neg_r_n  = neg_r_q;
    rd_n     = rd_q;
    dvs_n    = dvs_q;
    rem_n    = rem_q;
    quo_n    = quo_q;
    done_n   = 1'b0;
    we_n     = 1'b0;
    waddr_n  = '0;
    wdata_n  = '0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          is_rem_n = op[1];
          rd_n     = rd_addr;
          cnt_n    = '0;
          if (rs2_val == '0) begin
            // Divide by zero: quotient all ones, remainder is the raw
            // dividend. No sign fix-up applies to either.
            quo_n   = '1;
            rem_n   = rs1_val;
            dvs_n   = '0;
            neg_q_n = 1'b0;
            neg_r_n = 1'b0;
            state_n = DONE;
            done_n  = 1'b1;
            we_n    = (rd_addr != '0);
            waddr_n = rd_addr;
            wdata_n = op[1] ? rs1_val : '1;
          end else begin
            quo_n   = abs_rs1;
            rem_n   = '0;
            dvs_n   = abs_rs2;
            neg_q_n = op_signed & (rs1_val[DATA_WIDTH-1] ^ rs2_val[DATA_WIDTH-1]);
            neg_r_n = op_signed & rs1_val[DATA_WIDTH-1];
            state_n = CALC;
          end
        end
      end

      CALC: begin
        rem_n = step_rem;
        quo_n = step_quo;
        cnt_n = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
          state_n = DONE;
          done_n  = 1'b1;
          we_n    = (rd_q != '0);
          waddr_n = rd_q;
          wdata_n = final_neg ? -final_mag : final_mag;
        end
      end

      DONE: begin
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State, datapath and output registers; rst clears everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      is_rem_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      rd_q     <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      done_q   <= 1'b0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_n;
      cnt_q    <= cnt_n;
      is_rem_q <= is_rem_n;
      neg_q_q  <= neg_q_n;
      neg_r_q  <= neg_r_n;
      rd_q     <= rd_n;
      dvs_q    <= dvs_n;
      rem_q    <= rem_n;
      quo_q    <= quo_n;
      done_q   <= done_n;
      we_q     <= we_n;
      waddr_q  <= waddr_n;
      wdata_q  <= wdata_n;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign rf_we     = we_q;
  assign rf_waddr  = waddr_q;
  assign rf_wdata  = wdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed and randomized checks of div_unit against an
// arithmetic reference of the RV32M divide rules.
module tb_div_unit;

  localparam int W  = 32;
  localparam int AW = 5;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [1:0]    op;
  logic [W-1:0]  rs1_val;
  logic [W-1:0]  rs2_val;
  logic [AW-1:0] rd_addr;
  logic          busy;
  logic          done;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [W-1:0]  rf_wdata;
  logic [1:0]    dbg_state;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [1:0]    op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [AW-1:0] rd;
    logic [W-1:0]  exp;
    int            lat;
  } vec_t;

  div_unit #(.DATA_WIDTH(W), .ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .rs1_val   (rs1_val),
    .rs2_val   (rs2_val),
    .rd_addr   (rd_addr),
    .busy      (busy),
    .done      (done),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .dbg_state (dbg_state)
  );

  // Clock and reset
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: RV32M divide semantics in plain arithmetic.
  function automatic logic [W-1:0] ref_result(input logic [1:0] o,
                                              input logic [W-1:0] a,
                                              input logic [W-1:0] b);
    logic signed [W-1:0] sa;
    logic signed [W-1:0] sb;
    sa = a;
    sb = b;
    if (b == 0) return o[1] ? a : {W{1'b1}};
    if (!o[0]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
        return o[1] ? 32'h0 : 32'h8000_0000;
      return o[1] ? W'(sa % sb) : W'(sa / sb);
    end
    return o[1] ? (a % b) : (a / b);
  endfunction

  // busy expected high from T+1 through the DONE cycle T+lat.
  function automatic logic [63:0] busy_profile(input int lat);
    return ((64'd1 << (lat + 1)) - 64'd1) ^ 64'd1;
  endfunction

  // Driver: present a request for one cycle, then scramble the inputs.
  task automatic launch(input logic [1:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [AW-1:0] rd);
    op      = o;
    rs1_val = a;
    rs2_val = b;
    rd_addr = rd;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    op      = 2'($urandom);
    rs1_val = $urandom;
    rs2_val = $urandom;
    rd_addr = AW'($urandom);
  endtask

  // Monitor: sample ncyc cycles at the falling edge (index 1 = first cycle).
  task automatic observe(input int ncyc, output int done_n, output int done_at,
                         output logic we, output logic [AW-1:0] wa,
                         output logic [W-1:0] wd, output logic [63:0] bmask,
                         output int leak);
    done_n  = 0;
    done_at = 0;
    we      = 1'b0;
    wa      = '0;
    wd      = '0;
    bmask   = '0;
    leak    = 0;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      bmask[k] = busy;
      if (done) begin
        done_n++;
        if (done_n == 1) begin
          done_at = k;
          we      = rf_we;
          wa      = rf_waddr;
          wd      = rf_wdata;
        end
      end else if (rf_we || rf_waddr != 0 || rf_wdata != 0) begin
        leak++;
      end
    end
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    start   = 1'b1;
    op      = OP_DIVU;
    rs1_val = 32'd100;
    rs2_val = 32'd7;
    rd_addr = 5'd5;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b0;
    rst   = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++;
    if (rf_we !== 1'b0) begin bad++; $display("FAIL reset_we got=%b exp=0", rf_we); end
    total++;
    if (rf_waddr !== 5'd0) begin bad++; $display("FAIL reset_waddr got=%0d exp=0", rf_waddr); end
    total++;
    if (rf_wdata !== 32'd0) begin bad++; $display("FAIL reset_wdata got=%h exp=0", rf_wdata); end
  endtask

  task automatic test_directed();
    vec_t        v[13];
    int          dn, dat, lk;
    logic        we;
    logic [AW-1:0] wa;
    logic [W-1:0]  wd;
    logic [63:0]   bm;
    v[0]  = '{OP_DIVU, 32'd100,        32'd7,          5'd5, 32'd14,         33};
    v[1]  = '{OP_REMU, 32'd100,        32'd7,          5'd5, 32'd2,          33};
    v[2]  = '{OP_DIV,  32'hFFFF_FFF9,  32'd2,          5'd3, 32'hFFFF_FFFD,  33};
    v[3]  = '{OP_REM,  32'hFFFF_FFF9,  32'd2,          5'd3, 32'hFFFF_FFFF,  33};
    v[4]  = '{OP_DIV,  32'd7,          32'hFFFF_FFFE,  5'd4, 32'hFFFF_FFFD,  33};
    v[5]  = '{OP_REM,  32'd7,          32'hFFFF_FFFE,  5'd4, 32'd1,          33};
    v[6]  = '{OP_DIV,  32'h1234_5678,  32'd0,          5'd9, 32'hFFFF_FFFF,  1};
    v[7]  = '{OP_REMU, 32'h1234_5678,  32'd0,          5'd9, 32'h1234_5678,  1};
    v[8]  = '{OP_REM,  32'hFFFF_FFF0,  32'd0,          5'd9, 32'hFFFF_FFF0,  1};
    v[9]  = '{OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  5'd1, 32'h8000_0000,  33};
    v[10] = '{OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  5'd1, 32'd0,          33};
    v[11] = '{OP_DIVU, 32'd50,         32'd5,          5'd0, 32'd10,         33};
    v[12] = '{OP_DIVU, 32'hFFFF_FFFF,  32'd0,          5'd31, 32'hFFFF_FFFF, 1};
    for (int i = 0; i < 13; i++) begin
      launch(v[i].op, v[i].a, v[i].b, v[i].rd);
      observe(v[i].lat + 2, dn, dat, we, wa, wd, bm, lk);
      total++;
      if (dn !== 1 || dat !== v[i].lat) begin
        bad++; $display("FAIL dir%0d_done count=%0d at=%0d exp count=1 at=%0d", i, dn, dat, v[i].lat);
      end
      total++;
      if (wd !== v[i].exp) begin bad++; $display("FAIL dir%0d_wdata got=%h exp=%h", i, wd, v[i].exp); end
      total++;
      if (we !== (v[i].rd != 0)) begin bad++; $display("FAIL dir%0d_we got=%b exp=%b", i, we, v[i].rd != 0); end
      total++;
      if (wa !== v[i].rd) begin bad++; $display("FAIL dir%0d_waddr got=%0d exp=%0d", i, wa, v[i].rd); end
      total++;
      if (bm !== busy_profile(v[i].lat)) begin
        bad++; $display("FAIL dir%0d_busy got=%h exp=%h", i, bm, busy_profile(v[i].lat));
      end
      total++;
      if (lk !== 0) begin bad++; $display("FAIL dir%0d_idle_outputs got=%0d exp=0", i, lk); end
    end
  endtask

  task automatic test_start_while_busy();
    int          dn, dat, lk;
    logic        we;
    logic [AW-1:0] wa;
    logic [W-1:0]  wd;
    logic [63:0]   bm;
    launch(OP_DIVU, 32'd50, 32'd5, 5'd6);
    observe(9, dn, dat, we, wa, wd, bm, lk);
    @(posedge clk);
    #1;
    launch(OP_DIVU, 32'd1, 32'd1, 5'd7);
    // Window now starts at T+11; DONE at T+33 is index 23.
    observe(25, dn, dat, we, wa, wd, bm, lk);
    total++;
    if (dn !== 1 || dat !== 23) begin
      bad++; $display("FAIL busy_start_done count=%0d at=%0d exp count=1 at=23", dn, dat);
    end
    total++;
    if (wd !== 32'd10 || wa !== 5'd6 || we !== 1'b1) begin
      bad++; $display("FAIL busy_start_result got=%h/%0d/%b exp=0000000a/6/1", wd, wa, we);
    end
  endtask

  task automatic test_back_to_back();
    int          dn, dat, lk;
    logic        we;
    logic [AW-1:0] wa;
    logic [W-1:0]  wd;
    logic [63:0]   bm;
    launch(OP_DIVU, 32'd100, 32'd7, 5'd5);
    observe(33, dn, dat, we, wa, wd, bm, lk);
    total++;
    if (dn !== 1 || dat !== 33 || wd !== 32'd14) begin
      bad++; $display("FAIL b2b_first count=%0d at=%0d data=%h exp 1/33/0000000e", dn, dat, wd);
    end
    @(posedge clk);
    #1;
    launch(OP_REMU, 32'd9, 32'd4, 5'd8);
    observe(35, dn, dat, we, wa, wd, bm, lk);
    total++;
    if (dn !== 1 || dat !== 33 || wd !== 32'd1 || wa !== 5'd8) begin
      bad++; $display("FAIL b2b_second count=%0d at=%0d data=%h addr=%0d exp 1/33/00000001/8", dn, dat, wd, wa);
    end
  endtask

  task automatic test_reset_mid();
    int          dn, dat, lk;
    logic        we;
    logic [AW-1:0] wa;
    logic [W-1:0]  wd;
    logic [63:0]   bm;
    launch(OP_DIVU, 32'd1000, 32'd3, 5'd2);
    observe(9, dn, dat, we, wa, wd, bm, lk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || rf_we !== 1'b0) begin
      bad++; $display("FAIL midrst_outputs got busy=%b done=%b we=%b exp 0/0/0", busy, done, rf_we);
    end
    observe(40, dn, dat, we, wa, wd, bm, lk);
    total++;
    if (dn !== 0 || bm !== 64'd0) begin
      bad++; $display("FAIL midrst_no_done count=%0d busy=%h exp 0/0", dn, bm);
    end
    launch(OP_DIVU, 32'd9, 32'd3, 5'd4);
    observe(35, dn, dat, we, wa, wd, bm, lk);
    total++;
    if (dn !== 1 || dat !== 33 || wd !== 32'd3 || wa !== 5'd4 || we !== 1'b1) begin
      bad++; $display("FAIL midrst_after count=%0d at=%0d data=%h addr=%0d we=%b exp 1/33/00000003/4/1",
                      dn, dat, wd, wa, we);
    end
  endtask

  task automatic test_random();
    int          dn, dat, lk, lat, cat;
    logic        we;
    logic [AW-1:0] wa, rd;
    logic [W-1:0]  wd, a, b, exp;
    logic [1:0]    o;
    logic [63:0]   bm;
    for (int i = 0; i < 40; i++) begin
      o   = 2'($urandom);
      rd  = AW'($urandom);
      cat = $urandom_range(0, 9);
      a   = $urandom;
      b   = $urandom;
      if (cat == 0) b = 32'd0;
      else if (cat == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (cat <= 4) begin a = $urandom_range(0, 5000); b = $urandom_range(1, 40); end
      else if (cat == 5) b = $urandom_range(1, 3);
      if ($urandom_range(0, 3) == 0) a = -a;
      if ($urandom_range(0, 3) == 0) b = -b;
      exp_q.push_back(ref_result(o, a, b));
      lat = (b == 0) ? 1 : 33;
      launch(o, a, b, rd);
      observe(35, dn, dat, we, wa, wd, bm, lk);
      exp = exp_q.pop_front();
      total++;
      if (dn !== 1 || dat !== lat) begin
        bad++; $display("FAIL rnd%0d_done count=%0d at=%0d exp count=1 at=%0d", i, dn, dat, lat);
      end
      total++;
      if (wd !== exp) begin
        bad++; $display("FAIL rnd%0d_wdata op=%0d a=%h b=%h got=%h exp=%h", i, o, a, b, wd, exp);
      end
      total++;
      if (we !== (rd != 0) || wa !== rd) begin
        bad++; $display("FAIL rnd%0d_wb got we=%b addr=%0d exp we=%b addr=%0d", i, we, wa, rd != 0, rd);
      end
    end
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    op      = 2'b00;
    rs1_val = '0;
    rs2_val = '0;
    rd_addr = '0;
    test_reset();
    test_directed();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative RV32M divide/remainder unit (DIV, DIVU, REM, REMU).
- Consumes the register-file read data (RD1/RD2) for a decoded M-extension divide.
- Produces a write-back triple (we, address, data) that drives the register-file write port (WE3/A3/WD3) through the write-back mux.
- Restoring algorithm, one quotient bit per cycle; start/busy/done handshake to the control unit for stalling.

Parameters:
- DATA_WIDTH, 32, operand/result width.
- ADDR_WIDTH, 5, destination register address width.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; accepted only in IDLE.
- op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
- rs1_val  input  DATA_WIDTH  dividend (RD1).
- rs2_val  input  DATA_WIDTH  divisor (RD2).
- rd_addr  input  ADDR_WIDTH  destination register.
- busy  output  1  high whenever not IDLE; control stalls PC/issue while high.
- done  output  1  one-cycle pulse, result valid.
- rf_we  output  1  register-file write enable (to WE3).
- rf_waddr  output  ADDR_WIDTH  write address (to A3).
- rf_wdata  output  DATA_WIDTH  write data (to WD3).

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset: state=IDLE, counter=0, all internal registers=0. Outputs busy=0, done=0, rf_we=0, rf_waddr=0, rf_wdata=0.
- States: IDLE, CALC, DONE.
- IDLE, start=1 (cycle T), normal case:
  - Capture op and rd_addr.
  - Capture magnitudes: |rs1|, |rs2| for signed ops, raw values for unsigned.
  - Capture neg_q = signed op & sign(rs1) ^ sign(rs2); neg_r = signed op & sign(rs1).
  - Go to CALC with counter=0.
- IDLE, start=1, rs2_val==0: go directly to DONE with the div-by-zero result.
- CALC, each cycle:
  - Shift {rem, quo} left by 1.
  - Trial subtract divisor from rem (DATA_WIDTH+1 bits); if non-negative, keep the difference and set quo LSB=1.
  - Increment counter; after DATA_WIDTH iterations (cycles T+1..T+32) go to DONE.
- DONE (one cycle):
  - done=1.
  - rf_wdata = quotient (DIV/DIVU) or remainder (REM/REMU); negate quotient if neg_q, remainder if neg_r.
  - rf_waddr = captured rd.
  - rf_we=1 unless captured rd==0; x0 is never written.
  - Next state IDLE.
- Outputs: done, rf_we, rf_waddr, rf_wdata are registered state outputs; they are 0 outside DONE (rf_wdata also 0).
- Latency:
  - Normal: start at T → DONE at T+33; write commits on the edge ending T+33.
  - Divide by zero: DONE at T+1.
  - busy=1 from T+1 through the DONE cycle inclusive.
- Divide by zero: quotient = all ones (DIV and DIVU); remainder = dividend unchanged (sign preserved).
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0. This falls out of the magnitude path; no special case.
- start while busy (CALC or DONE): ignored; inputs not sampled; no queuing.
- start in IDLE the cycle after DONE: accepted normally (back-to-back throughput, one op per 34 cycles).
- Operands and rd_addr need only be valid in the start cycle; later changes have no effect.
- rst asserted in any state, including mid-CALC or DONE: next cycle all outputs 0, state IDLE, no write issued. rst has priority over start.

Test Plan:
- DIVU rs1=100, rs2=7, rd=5, start at T → done=1, rf_we=1, rf_waddr=5, rf_wdata=14 only in T+33; busy=1 for T+1..T+33; REMU same operands → 2.
- DIV rs1=0xFFFFFFF9 (-7), rs2=2, rd=3 → rf_wdata=0xFFFFFFFD (-3); REM same → 0xFFFFFFFF (-1); DIV 7 / -2 → 0xFFFFFFFD, REM → 1.
- DIV 0x12345678 / 0, rd=9 → done and rf_we at T+1, rf_wdata=0xFFFFFFFF; REMU same → 0x12345678; REM 0xFFFFFFF0 / 0 → 0xFFFFFFF0.
- DIV 0x80000000 / 0xFFFFFFFF → rf_wdata=0x80000000 at T+33; REM → 0.
- DIVU 50/5 with rd=0 → done=1 at T+33, rf_we=0. In a separate run, pulse start with rs1=1, rs2=1 at T+10 during an op → ignored, original result (10) delivered, no second done. A start at T+34 is accepted.
- DIVU 1000/3 started, rst=1 at T+10 for one cycle → T+11: busy=0, done=0, rf_we=0, no done pulse ever for that op. New DIVU 9/3 after reset → rf_wdata=3, 33 cycles later.
